// File: rtl/spi_slave_regs_if.sv
// SPI pin bundle plus the write-report bus of spi_slave_regs.
//   sclk, cs_n, mosi : driven by the SPI master
//   miso, miso_oe    : serial read data and its output enable
//   spi_slv_valid    : one-clk pulse per committed write
//   spi_slv_addr     : address of the last committed write
//   spi_slv_data     : full register contents after the last committed write
interface spi_slave_regs_if #(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned DWIDTH = 32
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              spi_slv_valid;
  logic [AWIDTH-1:0] spi_slv_addr;
  logic [DWIDTH-1:0] spi_slv_data;

  modport master (
    output sclk, cs_n, mosi,
    input  miso, miso_oe, spi_slv_valid, spi_slv_addr, spi_slv_data
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output miso, miso_oe, spi_slv_valid, spi_slv_addr, spi_slv_data
  );
endinterface

// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder with a bank of 2^AWIDTH registers, DWIDTH bits each.
// Frames are {WR_EN, SIZE[1:0], ADDR, DATA}, MSB first. Writes merge into the
// low L bits of the addressed register and are reported on the bus; reads
// shift the low L bits out on miso.
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset
//   bus         : spi_slave_regs_if.slave (SPI pins + write-report bus)
//   frame_done  : one-clk pulse when a frame finishes its data phase
//   frame_err   : one-clk pulse when cs_n rises mid-frame
// Build option: define SPI_SLV_SYNC_EN for 2-FF input synchronizers; without
// it a single input register is used (only for clk-derived sclk).
module spi_slave_regs #(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned DWIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_slave_regs_if.slave bus,
  output logic            frame_done,
  output logic            frame_err
);
  localparam int unsigned H    = 3 + AWIDTH;
  localparam int unsigned CntW = $clog2(DWIDTH + H + 1);
  localparam int unsigned NReg = 2 ** AWIDTH;

  typedef enum logic [2:0] {StIdle, StHeader, StWdata, StRdata, StWait} state_e;

  // Pin order in the synchronizer vectors: {sclk, cs_n, mosi}.
  logic [2:0] pins;
  assign pins = {bus.sclk, bus.cs_n, bus.mosi};

`ifdef SPI_SLV_SYNC_EN
  logic [2:0] meta_q, meta_d;
`endif
  logic [2:0] sync_q, sync_d;
  logic [1:0] prev_q, prev_d;  // {sclk, cs_n} one clk later, for edge detection

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CntW-1:0]     len_q, len_d;
  logic [H-2:0]        hdr_q, hdr_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   shift_q, shift_d;
  logic [DWIDTH-1:0]   regs_q [NReg];
  logic [DWIDTH-1:0]   regs_d [NReg];
  logic                miso_q, miso_d;
  logic                oe_q, oe_d;
  logic                valid_q, valid_d;
  logic [AWIDTH-1:0]   out_addr_q, out_addr_d;
  logic [DWIDTH-1:0]   out_data_q, out_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic              cs_s, mosi_s, rise, fall, cs_fall;
  logic [H-1:0]      hdr_next;
  logic [DWIDTH-1:0] shift_in;
  logic [DWIDTH-1:0] mask;
  logic [DWIDTH-1:0] merged;
  logic [CntW-1:0]   new_len;

  function automatic logic [CntW-1:0] size_len(input logic [1:0] size);
    case (size)
      2'b00:   return CntW'(DWIDTH / 4);
      2'b01:   return CntW'(DWIDTH / 2);
      default: return CntW'(DWIDTH);
    endcase
  endfunction

  function automatic logic [DWIDTH-1:0] len_mask(input logic [CntW-1:0] len);
    logic [DWIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < int'(DWIDTH); i++) m[i] = (i < int'(len));
    return m;
  endfunction

  always_comb begin
`ifdef SPI_SLV_SYNC_EN
    meta_d = pins;
    sync_d = meta_q;
`else
    sync_d = pins;
`endif
    prev_d = sync_q[2:1];
  end

  assign cs_s    = sync_q[1];
  assign mosi_s  = sync_q[0];
  assign rise    = sync_q[2] & ~prev_q[1];
  assign fall    = ~sync_q[2] & prev_q[1];
  // A falling edge needs cs_n seen high first, so a cs_n held low across
  // reset release is ignored until it rises.
  assign cs_fall = ~sync_q[1] & prev_q[0];

  assign hdr_next = {hdr_q, mosi_s};
  assign shift_in = {shift_q[DWIDTH-2:0], mosi_s};
  assign mask     = len_mask(len_q);
  assign merged   = (regs_q[addr_q] & ~mask) | (shift_in & mask);
  assign new_len  = size_len(hdr_next[H-2:H-3]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    hdr_d      = hdr_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    regs_d     = regs_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    valid_d    = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d = StHeader;
          cnt_d   = '0;
          hdr_d   = '0;
        end
      end
      StHeader: begin
        if (cs_s) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (rise) begin
          hdr_d = hdr_next[H-2:0];
          if (cnt_q == CntW'(H - 1)) begin
            cnt_d  = '0;
            addr_d = hdr_next[AWIDTH-1:0];
            len_d  = new_len;
            if (hdr_next[H-1]) begin
              state_d = StWdata;
              shift_d = '0;
            end else begin
              state_d = StRdata;
              // Left-align the low L bits so the MSB to send sits at the top.
              shift_d = regs_q[hdr_next[AWIDTH-1:0]] << (DWIDTH - int'(new_len));
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWdata: begin
        if (cs_s) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (rise) begin
          shift_d = shift_in;
          if (cnt_q == len_q - 1'b1) begin
            regs_d[addr_q] = merged;
            valid_d        = 1'b1;
            out_addr_d     = addr_q;
            out_data_d     = merged;
            done_d         = 1'b1;
            state_d        = StWait;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRdata: begin
        if (cs_s) begin
          state_d = StIdle;
          err_d   = 1'b1;
          miso_d  = 1'b0;
          oe_d    = 1'b0;
        end else begin
          if (fall) begin
            miso_d  = shift_q[DWIDTH-1];
            oe_d    = 1'b1;
            shift_d = shift_q << 1;
          end
          if (rise) begin
            if (cnt_q == len_q - 1'b1) begin
              done_d  = 1'b1;
              state_d = StWait;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      StWait: begin
        // The falling edge after the last read bit releases miso.
        if (fall || cs_s) begin
          miso_d = 1'b0;
          oe_d   = 1'b0;
        end
        if (cs_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef SPI_SLV_SYNC_EN
      meta_q     <= '0;
`endif
      sync_q     <= '0;
      prev_q     <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      len_q      <= '0;
      hdr_q      <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      regs_q     <= '{default: '0};
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      valid_q    <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
`ifdef SPI_SLV_SYNC_EN
      meta_q     <= meta_d;
`endif
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      hdr_q      <= hdr_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      regs_q     <= regs_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      valid_q    <= valid_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.miso          = miso_q;
  assign bus.miso_oe       = oe_q;
  assign bus.spi_slv_valid = valid_q;
  assign bus.spi_slv_addr  = out_addr_q;
  assign bus.spi_slv_data  = out_data_q;
  assign frame_done        = done_q;
  assign frame_err         = err_q;
endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: sclk is derived from clk at f_clk/8.
module tb_spi_slave_regs;
  logic clk;
  logic rst_n;
  logic frame_done;
  logic frame_err;

  spi_slave_regs_if #(.AWIDTH(4), .DWIDTH(32)) bus ();

  spi_slave_regs #(.AWIDTH(4), .DWIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          valid_cnt = 0;
  int          done_cnt  = 0;
  int          err_cnt   = 0;
  int          oe_cnt    = 0;
  logic [3:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  always @(negedge clk) begin
    if (bus.miso_oe) oe_cnt++;
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (bus.spi_slv_valid) begin
      valid_cnt++;
      last_addr = bus.spi_slv_addr;
      last_data = bus.spi_slv_data;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One sclk period: 4 clk low with mosi set, rise, 4 clk high, fall.
  task automatic xfer_bit(input logic mo, output logic mi);
    bus.mosi = mo;
    repeat (4) @(negedge clk);
    mi = bus.miso;
    bus.sclk = 1'b1;
    repeat (4) @(negedge clk);
    bus.sclk = 1'b0;
  endtask

  // nbits < 0 sends the whole frame; otherwise cs_n rises after nbits sclks.
  task automatic run_frame(input logic wr, input logic [1:0] size, input logic [3:0] addr,
                           input logic [31:0] data, input int nbits, input int extra,
                           output logic [31:0] rdata);
    logic [6:0] hdr;
    logic       mi;
    int         len;
    int         nsend;
    hdr   = {wr, size, addr};
    len   = (size == 2'b00) ? 8 : (size == 2'b01) ? 16 : 32;
    nsend = (nbits < 0) ? 7 + len : nbits;
    rdata = '0;
    bus.cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nsend; i++) begin
      if (i < 7) xfer_bit(hdr[6-i], mi);
      else begin
        xfer_bit(data[len-1-(i-7)], mi);
        rdata = {rdata[30:0], mi};
      end
    end
    for (int i = 0; i < extra; i++) xfer_bit(1'b1, mi);
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  int          v0, d0, e0, o0;
  logic [31:0] rd;
  logic        mi_dummy;

  task automatic snap();
    v0 = valid_cnt;
    d0 = done_cnt;
    e0 = err_cnt;
    o0 = oe_cnt;
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_miso", bus.miso, 0);
    check_eq("rst_oe", bus.miso_oe, 0);
    check_eq("rst_valid", bus.spi_slv_valid, 0);
    check_eq("rst_addr", bus.spi_slv_addr, 0);
    check_eq("rst_data", bus.spi_slv_data, 0);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_err", frame_err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Full-width write.
    snap();
    run_frame(1'b1, 2'b10, 4'd3, 32'hDEADBEEF, -1, 0, rd);
    check_eq("w32_valid_cnt", valid_cnt - v0, 1);
    check_eq("w32_done_cnt", done_cnt - d0, 1);
    check_eq("w32_addr", last_addr, 3);
    check_eq("w32_data", last_data, 32'hDEADBEEF);
    check_eq("w32_port_data", bus.spi_slv_data, 32'hDEADBEEF);
    check_eq("w32_oe_cnt", oe_cnt - o0, 0);

    // Byte write keeps upper bits; followed by extra sclks in WAIT.
    snap();
    run_frame(1'b1, 2'b00, 4'd3, 32'h000000A5, -1, 5, rd);
    check_eq("w8_valid_cnt", valid_cnt - v0, 1);
    check_eq("w8_done_cnt", done_cnt - d0, 1);
    check_eq("w8_data", last_data, 32'hDEADBEA5);

    // Full-width read.
    snap();
    run_frame(1'b0, 2'b10, 4'd3, 32'h0, -1, 0, rd);
    check_eq("r32_data", rd, 32'hDEADBEA5);
    check_eq("r32_oe_cycles", oe_cnt - o0, 32 * 8);
    check_eq("r32_valid_cnt", valid_cnt - v0, 0);
    check_eq("r32_done_cnt", done_cnt - d0, 1);
    check_eq("r32_miso_after", bus.miso, 0);

    // Half-width read with 5 extra sclks after data.
    snap();
    run_frame(1'b0, 2'b01, 4'd3, 32'h0, -1, 5, rd);
    check_eq("r16_data", rd, 32'h0000BEA5);
    check_eq("r16_oe_cycles", oe_cnt - o0, 16 * 8);
    check_eq("r16_done_cnt", done_cnt - d0, 1);
    check_eq("r16_oe_after", bus.miso_oe, 0);
    check_eq("r16_port_data", bus.spi_slv_data, 32'hDEADBEA5);

    // Aborted write to address 5.
    snap();
    run_frame(1'b1, 2'b10, 4'd5, 32'h12345678, 20, 0, rd);
    check_eq("abort_err_cnt", err_cnt - e0, 1);
    check_eq("abort_valid_cnt", valid_cnt - v0, 0);
    check_eq("abort_done_cnt", done_cnt - d0, 0);
    snap();
    run_frame(1'b0, 2'b10, 4'd5, 32'h0, -1, 0, rd);
    check_eq("r5_data", rd, 32'h0);
    check_eq("r5_err_cnt", err_cnt - e0, 0);

    // Reset in the middle of a read.
    snap();
    bus.cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      logic [6:0] h;
      h = {1'b0, 2'b10, 4'd3};
      xfer_bit((i < 7) ? h[6-i] : 1'b0, mi_dummy);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mrst_oe", bus.miso_oe, 0);
    check_eq("mrst_miso", bus.miso, 0);
    check_eq("mrst_data", bus.spi_slv_data, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // cs_n still low from before reset: these sclks must be ignored.
    for (int i = 0; i < 3; i++) xfer_bit(1'b1, mi_dummy);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("mrst_err_cnt", err_cnt - e0, 0);
    check_eq("mrst_done_cnt", done_cnt - d0, 0);
    run_frame(1'b0, 2'b10, 4'd3, 32'h0, -1, 0, rd);
    check_eq("mrst_read3", rd, 32'h0);
    check_eq("mrst_valid_cnt", valid_cnt - v0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI responder at the far end of the SPI master's serial link. It receives instruction frames {WR_EN, SIZE, ADDR, DATA} on MOSI and executes them against an internal bank of 2^AWIDTH registers, each DWIDTH bits wide. On reads it returns register data on MISO. On writes it reports the updated register on the spi_slv_addr/spi_slv_data bus, which the system side uses as the slave's observable state.

## Interface
- AWIDTH, 4: register address width; bank depth 2^AWIDTH.
- DWIDTH, 32: register width; multiple of 4, minimum 8.

- clk  input  1  global clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- sclk  input  1  SPI clock from master, asynchronous to clk; mode 0 (CPOL=0, CPHA=0).
- cs_n  input  1  active-low slave select.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master.
- miso_oe  output  1  MISO output enable, high only while read data is driven.
- spi_slv_valid  output  1  one-clk pulse when a write frame commits.
- spi_slv_addr  output  AWIDTH  address of the last committed write.
- spi_slv_data  output  DWIDTH  full register contents after the last committed write.
- frame_done  output  1  one-clk pulse when a frame completes its data phase.
- frame_err  output  1  one-clk pulse when cs_n rises mid-frame.

## Operation
- Frame order, bit by bit: WR_EN, SIZE[1], SIZE[0], ADDR (MSB first), then data (MSB first). Header length is H = 3+AWIDTH bits.
- SIZE sets the data length L: 00 gives DWIDTH/4, 01 gives DWIDTH/2, 10 or 11 gives DWIDTH. Data always maps to the register's low L bits.
- mosi is sampled on the detected rising edge of sclk. miso changes on the detected falling edge.
- State machine:
  - IDLE: waits for cs_n falling, clears the bit counter, goes to HEADER.
  - HEADER: shifts in H bits. After bit H, goes to WDATA if WR_EN=1, otherwise RDATA.
  - WDATA: shifts in L bits. After bit L, merges the shifted value into the low L bits of reg[ADDR], keeps the upper bits, pulses spi_slv_valid and frame_done, goes to WAIT.
  - RDATA: loads shift = reg[ADDR] low L bits. On the falling edge after header bit H, sets miso_oe=1 and drives the MSB. Each later falling edge drives the next bit. After the L-th data rising edge, pulses frame_done and goes to WAIT. On the next falling edge, miso_oe=0 and miso=0.
  - WAIT: ignores sclk until cs_n rises, then goes to IDLE.
- cs_n rising in HEADER, WDATA or RDATA: abort to IDLE, pulse frame_err, no register update, miso_oe=0 within the same clk.
- cs_n rising in WAIT or IDLE: no error.
- Extra sclk edges in WAIT are ignored. miso stays 0 and miso_oe stays 0.
- When a read targets the address being written in the same clk, the read returns the old value. This case cannot occur because frames are serial.

## Timing
- Synchronizer latency S: 2 clk with SPI_SLV_SYNC_EN, 1 clk without. An edge is detected S+1 clk after the pin transition.
- miso updates S+2 clk after a sclk falling edge at the pin. This requires f_clk ≥ 8×f_sclk.
- Write commit: spi_slv_valid, spi_slv_addr/spi_slv_data and the register update all occur 1 clk after the last data rising edge is detected.
- frame_done and frame_err are exactly 1 clk wide.
- Reset, checked at posedge clk with rst_n=0: state returns to IDLE; all registers, shift register and counters clear to 0; miso, miso_oe, spi_slv_valid, spi_slv_addr, spi_slv_data, frame_done and frame_err are all 0. Reset mid-frame discards the frame with no frame_err.
- After rst_n rises, the block accepts a frame only after observing cs_n high for at least 1 synchronized clk. A cs_n already low at reset release is ignored until it rises.

## Configuration
- SPI_SLV_SYNC_EN defined: sclk, cs_n and mosi each pass through a 2-FF synchronizer before edge detection. Required for silicon and for asynchronous benches.
- SPI_SLV_SYNC_EN undefined: a single input register, S=1. Only for benches where sclk is generated from clk. All other behaviour is identical apart from the latency shift.

## Test plan
- Write, SIZE=10, ADDR=3, data 0xDEADBEEF → spi_slv_valid pulses once with spi_slv_addr=3 and spi_slv_data=0xDEADBEEF; frame_done pulses once.
- Write, SIZE=00, ADDR=3, data 0xA5 → spi_slv_data=0xDEADBEA5 (upper 24 bits kept).
- Read, SIZE=10, ADDR=3 → MISO carries 0xDEADBEA5 MSB first. miso_oe is high for exactly 32 bit periods. No spi_slv_valid.
- Read, SIZE=01, ADDR=3 → MISO carries 0xBEA5 over 16 bits.
- Write to ADDR=5 with cs_n raised after 20 sclk → frame_err pulses, no spi_slv_valid; a later read of ADDR=5 returns 0.
- rst_n low for 2 clk mid-read → miso_oe=0 and all outputs 0; a subsequent read of ADDR=3 returns 0. Five extra sclk after any frame's data → no state change.
